rv32m_divider: RTL and testbench

Iterative M-extension divide unit for the single-cycle RV32I core. Consumes the two register-file read values (DataA = rs1, DataB = rs2) for DIV/DIVU/REM/REMU and produces a register-file write strobe (WE/AddD/DataD) 34 cycles later. The core stalls on `busy`, and the writeback mux gives this block's WE/AddD/DataD priority while `done` is high.

---
 rtl/rv32m_pkg.sv | 21 ++
 rtl/rv32m_divider_if.sv | 26 ++
 rtl/rv32_div_step.sv | 19 +
 rtl/rv32m_divider.sv | 150 +++++++++++++++
 tb/tb_rv32m_divider.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M iterative divider: op codes, FSM states
// and the two operand constants used by the special-case detection.
package rv32m_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/rv32m_divider_if.sv
// Request/writeback bundle of the divider.
// master: start/op/rd/DataA/DataB out, busy/done/WE/AddD/DataD in; slave: mirror.
interface rv32m_divider_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [4:0]      rd;
    logic [XLEN-1:0] DataA;
    logic [XLEN-1:0] DataB;
    logic            busy;
    logic            done;
    logic            WE;
    logic [4:0]      AddD;
    logic [XLEN-1:0] DataD;

    modport master (
        output start, op, rd, DataA, DataB,
        input  busy, done, WE, AddD, DataD
    );

    modport slave (
        input  start, op, rd, DataA, DataB,
        output busy, done, WE, AddD, DataD
    );
endinterface

// File: rtl/rv32_div_step.sv
// One combinational radix-2 restoring division step.
// Ports: prem (partial remainder), dbit (next dividend bit), divisor in; next_rem, qbit out.
module rv32_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   prem,
    input  logic            dbit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   next_rem,
    output logic            qbit
);
    // One extra bit on top of the shifted remainder so the MSB is a clean
    // borrow flag for the trial subtraction.
    logic [XLEN+1:0] trial;

    assign trial    = {prem, dbit} - {2'b00, divisor};
    assign qbit     = ~trial[XLEN+1];
    assign next_rem = qbit ? trial[XLEN:0] : {prem[XLEN-1:0], dbit};
endmodule

// File: rtl/rv32m_divider.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: 34-cycle latency, 2 for special cases.
// Ports: clk, rst (sync active-low), bus (slave modport of rv32m_divider_if).
module rv32m_divider
    import rv32m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic            clk,
    input logic            rst,
    rv32m_divider_if.slave bus
);
    state_e          state;
    state_e          state_d;
    logic [5:0]      cnt;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] quo;
    logic [XLEN:0]   prem;
    logic [XLEN:0]   prem_d;
    logic            qbit;
    logic            qneg;
    logic            rneg;
    logic            rem_sel;
    logic [4:0]      rd_q;

    logic            done_q;
    logic            we_q;
    logic [4:0]      add_q;
    logic [XLEN-1:0] data_q;

    logic            is_signed;
    logic            div_zero;
    logic            overflow;
    logic            last;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    assign is_signed = (bus.op == OP_DIV) || (bus.op == OP_REM);
    assign div_zero  = (bus.DataB == '0);
    assign overflow  = is_signed && (bus.DataA == INT_MIN) && (bus.DataB == ALL_ONES);

    // Special cases preload quo/prem and jump the counter to its end value,
    // so they leave CALC on the very next edge through the normal exit path.
    assign last  = (cnt == 6'd32);
    assign q_fix = qneg ? -quo : quo;
    assign r_fix = rneg ? -prem[XLEN-1:0] : prem[XLEN-1:0];

    rv32_div_step #(.XLEN(XLEN)) u_step (
        .prem     (prem),
        .dbit     (dvd[XLEN-1]),
        .divisor  (dvs),
        .next_rem (prem_d),
        .qbit     (qbit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_d = S_CALC;
            S_CALC:  if (last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            dvd     <= '0;
            dvs     <= '0;
            quo     <= '0;
            prem    <= '0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            rem_sel <= 1'b0;
            rd_q    <= '0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            add_q   <= '0;
            data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        rd_q    <= bus.rd;
                        rem_sel <= (bus.op == OP_REM) || (bus.op == OP_REMU);
                        unique case (1'b1)
                            div_zero: begin
                                quo  <= ALL_ONES;
                                prem <= {1'b0, bus.DataA};
                                qneg <= 1'b0;
                                rneg <= 1'b0;
                                cnt  <= 6'd32;
                            end
                            overflow: begin
                                quo  <= INT_MIN;
                                prem <= '0;
                                qneg <= 1'b0;
                                rneg <= 1'b0;
                                cnt  <= 6'd32;
                            end
                            default: begin
                                quo  <= '0;
                                prem <= '0;
                                cnt  <= '0;
                                dvd  <= (is_signed && bus.DataA[XLEN-1])
                                        ? -bus.DataA : bus.DataA;
                                dvs  <= (is_signed && bus.DataB[XLEN-1])
                                        ? -bus.DataB : bus.DataB;
                                qneg <= is_signed
                                        && (bus.DataA[XLEN-1] ^ bus.DataB[XLEN-1]);
                                rneg <= is_signed && bus.DataA[XLEN-1];
                            end
                        endcase
                    end
                end
                S_CALC: begin
                    if (last) begin
                        data_q <= rem_sel ? r_fix : q_fix;
                        add_q  <= rd_q;
                        done_q <= 1'b1;
                        we_q   <= (rd_q != 5'd0);
                    end else begin
                        prem <= prem_d;
                        quo  <= {quo[XLEN-2:0], qbit};
                        dvd  <= {dvd[XLEN-2:0], 1'b0};
                        cnt  <= cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state != S_IDLE);
    assign bus.done  = done_q;
    assign bus.WE    = we_q;
    assign bus.AddD  = add_q;
    assign bus.DataD = data_q;
endmodule

// File: tb/tb_rv32m_divider.sv
// Self-checking bench for rv32m_divider: directed table, random ops against
// a plain-arithmetic model, and hand sequences for start-ignore and reset.
module tb_rv32m_divider;
    import rv32m_pkg::*;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    vec_t vecs[$];

    rv32m_divider_if #(.XLEN(32)) bus ();

    rv32m_divider #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 32'd0) return 2;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    task automatic add(input string name, input logic [1:0] op,
                       input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input int lat);
        vec_t v;
        v.name = name;
        v.op   = op;
        v.rd   = rd;
        v.a    = a;
        v.b    = b;
        v.exp  = exp;
        v.lat  = lat;
        vecs.push_back(v);
    endtask

    // Issues one op, waits (bounded) for done, and checks the write strobe,
    // the latency in edges from the start edge to the write edge, and the
    // single-cycle pulse.
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int lat);
        int n;
        logic [31:0] held;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rd    = rd;
        bus.DataA = a;
        bus.DataB = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.DataA = $urandom;
        bus.DataB = $urandom;
        bus.op    = 2'($urandom);
        bus.rd    = 5'($urandom);
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, " latency"}, 32'(n + 1), 32'(lat));
        chk({name, " DataD"}, bus.DataD, exp);
        chk({name, " AddD"}, 32'(bus.AddD), 32'(rd));
        chk({name, " WE"}, 32'(bus.WE), 32'(rd != 5'd0));
        chk({name, " busy_in_done"}, 32'(bus.busy), 32'd1);
        held = bus.DataD;
        @(posedge clk);
        #1;
        chk({name, " done_pulse"}, 32'(bus.done), 32'd0);
        chk({name, " busy_after"}, 32'(bus.busy), 32'd0);
        chk({name, " DataD_hold"}, bus.DataD, held);
    endtask

    initial begin
        int          pulses;
        int          pulse_k;
        int          we_seen;
        logic [31:0] got;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.rd     = 5'd0;
        bus.DataA  = '0;
        bus.DataB  = '0;

        add("div_neg",   OP_DIV,  5'd5,  32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 34);
        add("rem_neg",   OP_REM,  5'd5,  32'd20,        32'hFFFF_FFFD, 32'h0000_0002, 34);
        add("rem_negA",  OP_REM,  5'd7,  32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 34);
        add("divu_big",  OP_DIVU, 5'd8,  32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 34);
        add("remu_big",  OP_REMU, 5'd9,  32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 34);
        add("div_zero",  OP_DIV,  5'd10, 32'd7,         32'd0,         32'hFFFF_FFFF, 2);
        add("remu_zero", OP_REMU, 5'd11, 32'd7,         32'd0,         32'd7,         2);
        add("div_ovf",   OP_DIV,  5'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        add("rem_ovf",   OP_REM,  5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2);
        add("divu_ovf",  OP_DIVU, 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34);
        add("rd_zero",   OP_DIVU, 5'd0,  32'd9,         32'd3,         32'd3,         34);
        add("div_trunc", OP_DIV,  5'd15, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        add("rem_negB",  OP_REM,  5'd16, 32'd7,         32'hFFFF_FFFE, 32'd1,         34);
        add("remu_mask", OP_REMU, 5'd31, 32'h1234_5678, 32'h100,       32'h78,        34);
        add("div_minb",  OP_DIV,  5'd1,  32'h8000_0000, 32'h8000_0000, 32'd1,         34);

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset WE", 32'(bus.WE), 32'd0);
        chk("reset AddD", 32'(bus.AddD), 32'd0);
        chk("reset DataD", bus.DataD, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].rd, vecs[i].a,
                   vecs[i].b, vecs[i].exp, vecs[i].lat);

        for (int i = 0; i < 150; i++) begin
            rop = 2'($urandom);
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 15);
                3:       rb = -($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op("rand", rop, 5'($urandom), ra, rb,
                   ref_model(rop, ra, rb), ref_lat(rop, ra, rb));
        end

        // Starts while busy, in CALC and in DONE, must be dropped.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.rd    = 5'd3;
        bus.DataA = 32'd100;
        bus.DataB = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        pulses  = 0;
        pulse_k = -1;
        got     = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.start = (k == 5 || k == 33 || k == 34);
            bus.op    = 2'($urandom);
            bus.DataA = $urandom;
            bus.DataB = $urandom_range(1, 100);
            @(posedge clk);
            #1;
            if (bus.done) begin
                pulses++;
                pulse_k = k;
                got     = bus.DataD;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("ignore pulses", 32'(pulses), 32'd1);
        chk("ignore edge", 32'(pulse_k), 32'd33);
        chk("ignore DataD", got, 32'd14);

        // Reset in the middle of CALC drops the pending result.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.rd    = 5'd6;
        bus.DataA = 32'd50;
        bus.DataB = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst done", 32'(bus.done), 32'd0);
        chk("midrst WE", 32'(bus.WE), 32'd0);
        chk("midrst DataD", bus.DataD, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        we_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.WE || bus.done) we_seen++;
        end
        chk("midrst no_write", 32'(we_seen), 32'd0);
        run_op("post_rst", OP_DIV, 5'd4, 32'd6, 32'd2, 32'd3, 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
